// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants, counter-width compare values and scene
// colours for the 1280x1024@60 side-scroller generator.
package vga_pkg;

  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 48;
  localparam int H_SYNC   = 112;
  localparam int H_TOTAL  = 1688;
  localparam int V_ACTIVE = 1024;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 3;
  localparam int V_TOTAL  = 1066;

  localparam int CNT_W      = 11;
  localparam int TILE_SHIFT = 6;

  // Counter-width versions so compares against hcnt/vcnt are width-exact.
  localparam logic [CNT_W-1:0] H_ACTIVE_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_FIRST_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST_C  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_ACTIVE_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] VS_FIRST_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST_C  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Scene layout in tile units.
  localparam logic [4:0] GROUND_ROW = 5'd14;
  localparam logic [4:0] BLOCK_ROW  = 5'd10;
  localparam logic [6:0] BLOCK_COL  = 7'd5;

  // 12-bit colours, {R,G,B} nibbles.
  localparam logic [11:0] SKY    = 12'h59F;
  localparam logic [11:0] BRICK  = 12'hC40;
  localparam logic [11:0] QBLOCK = 12'hFA0;
  localparam logic [11:0] BLACK  = 12'h000;

endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: horizontal/vertical raster counters and timing decode.
// Ports:
//   clk, rst    - pixel clock, synchronous active-high reset
//   hcnt, vcnt  - current pixel column / line
//   active      - inside the visible 1280x1024 window
//   hs_c, vs_c  - unregistered sync pulses (positive polarity)
//   frame_end   - high on the last clock of the frame (1687,1065)
module vga_sync_counter
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             active,
  output logic             hs_c,
  output logic             vs_c,
  output logic             frame_end
);

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST_C) begin
      hcnt_d = '0;
      if (vcnt_q == V_LAST_C) vcnt_d = '0;
      else                    vcnt_d = vcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt      = hcnt_q;
  assign vcnt      = vcnt_q;
  assign active    = (hcnt_q < H_ACTIVE_C) && (vcnt_q < V_ACTIVE_C);
  assign hs_c      = (hcnt_q >= HS_FIRST_C) && (hcnt_q <= HS_LAST_C);
  assign vs_c      = (vcnt_q >= VS_FIRST_C) && (vcnt_q <= VS_LAST_C);
  assign frame_end = (hcnt_q == H_LAST_C) && (vcnt_q == V_LAST_C);

endmodule

// File: rtl/vga_scene_gen.sv
// vga_scene_gen: 1280x1024@60 VGA timing plus a procedural scrolling scene
// (sky, ground band with mortar lines, question blocks every 8 tiles).
// Ports:
//   clk, rst                - 108 MHz pixel clock, synchronous active-high reset
//   view[6:0]               - camera position in 64-pixel world tiles
//   O_red/O_green/O_blue    - registered 4-bit colour, one clock after counters
//   hs, vs                  - registered positive-polarity syncs
module vga_scene_gen
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] view,
  output logic [3:0] O_red,
  output logic [3:0] O_green,
  output logic [3:0] O_blue,
  output logic       hs,
  output logic       vs
);

  logic [CNT_W-1:0] hcnt, vcnt;
  logic             active, hs_c, vs_c, frame_end;

  vga_sync_counter u_sync (
    .clk       (clk),
    .rst       (rst),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .active    (active),
    .hs_c      (hs_c),
    .vs_c      (vs_c),
    .frame_end (frame_end)
  );

  logic [6:0]  view_q, view_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;

  logic [12:0] world_x;
  logic [6:0]  tc;
  logic [5:0]  px, py;
  logic [4:0]  tr;

  // Camera only moves on the frame boundary so a frame is never split.
  assign view_d = frame_end ? view : view_q;

  // Sum is allowed to carry into bit 12; tile column wraps modulo 128.
  assign world_x = (13'(view_q) << TILE_SHIFT) + 13'(hcnt);
  assign tc      = world_x[12:TILE_SHIFT];
  assign px      = world_x[TILE_SHIFT-1:0];
  // Bit 10 of vcnt is only set in vertical blanking, where the image is
  // already forced black, so a 5-bit row behaves like the 4-bit one.
  assign tr      = vcnt[10:TILE_SHIFT];
  assign py      = vcnt[TILE_SHIFT-1:0];

  always_comb begin
    rgb_d = SKY;
    if (!active) begin
      rgb_d = BLACK;
    end else if (tr >= GROUND_ROW) begin
      if (px == 6'd0 || py == 6'd0 || py == 6'd32) rgb_d = BLACK;
      else                                         rgb_d = BRICK;
    end else if (tr == BLOCK_ROW && (tc & 7'd7) == BLOCK_COL) begin
      if (px < 6'd4 || px >= 6'd60 || py < 6'd4 || py >= 6'd60) rgb_d = BLACK;
      else                                                      rgb_d = QBLOCK;
    end
    hs_d = hs_c;
    vs_d = vs_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      view_q <= '0;
      rgb_q  <= '0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
    end else begin
      view_q <= view_d;
      rgb_q  <= rgb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
    end
  end

  assign O_red   = rgb_q[11:8];
  assign O_green = rgb_q[7:4];
  assign O_blue  = rgb_q[3:0];
  assign hs      = hs_q;
  assign vs      = vs_q;

endmodule

// File: tb/tb_vga_scene_gen.sv
module tb_vga_scene_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] view = 7'd0;
  logic [3:0] O_red, O_green, O_blue;
  logic       hs, vs;

  vga_scene_gen dut (
    .clk     (clk),
    .rst     (rst),
    .view    (view),
    .O_red   (O_red),
    .O_green (O_green),
    .O_blue  (O_blue),
    .hs      (hs),
    .vs      (vs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    int          h;
    int          v;
  } exp_t;

  exp_t sb[$];
  int   hm = 0, vm = 0, viewm = 0;
  bit   vforced = 0;
  int   last_h = -1, last_v = -1;
  int   n_assert = 0, n_fail = 0;

  function automatic logic [11:0] model_rgb(int h, int v, int vw);
    int wx, tc, px, tr, py;
    if (h >= 1280 || v >= 1024) return 12'h000;
    wx = (vw * 64 + h) % 8192;
    tc = (wx / 64) % 128;
    px = wx % 64;
    tr = v / 64;
    py = v % 64;
    if (tr >= 14) return (px == 0 || py == 0 || py == 32) ? 12'h000 : 12'hC40;
    if (tr == 10 && (tc % 8) == 5)
      return (px < 4 || px >= 60 || py < 4 || py >= 60) ? 12'h000 : 12'hFA0;
    return 12'h59F;
  endfunction

  // Model: at each edge, push what the outputs must show after that edge.
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      e.rgb = 12'h000; e.hs = 1'b0; e.vs = 1'b0; e.h = -1; e.v = -1;
      hm = 0; vm = 0; viewm = 0;
    end else begin
      e.rgb = model_rgb(hm, vm, viewm);
      e.hs  = (hm >= 1328 && hm <= 1439);
      e.vs  = (vm >= 1025 && vm <= 1027);
      e.h   = hm;
      e.v   = vm;
      if (hm == 1687) begin
        hm = 0;
        if (vm == 1065) viewm = int'(view);
        if (!vforced) vm = (vm == 1065) ? 0 : vm + 1;
      end else begin
        hm = hm + 1;
      end
    end
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_assert++;
      assert ({O_red, O_green, O_blue, hs, vs} === {e.rgb, e.hs, e.vs})
      else begin
        n_fail++;
        $error("FAIL sb h=%0d v=%0d got rgb=%h hs=%b vs=%b exp rgb=%h hs=%b vs=%b",
               e.h, e.v, {O_red, O_green, O_blue}, hs, vs, e.rgb, e.hs, e.vs);
      end
      last_h = e.h;
      last_v = e.v;
    end
  end

  task automatic check_pix(input int x, input int y, input logic [11:0] exp_rgb,
                           input string tag);
    int k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (!(last_h == x && last_v == y) && k < 4000);
    n_assert++;
    assert (last_h == x && last_v == y && {O_red, O_green, O_blue} === exp_rgb)
    else begin
      n_fail++;
      $error("FAIL %s (%0d,%0d) got rgb=%h at (%0d,%0d) exp rgb=%h",
             tag, x, y, {O_red, O_green, O_blue}, last_h, last_v, exp_rgb);
    end
  endtask

  initial begin
    int rise1, rise2, hs_width;
    logic hs_prev;

    // Reset held for 10 clocks with a camera position already applied.
    view = 7'd10;
    rst  = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    n_assert++;
    assert ({O_red, O_green, O_blue, hs, vs} === 14'd0)
    else begin
      n_fail++;
      $error("FAIL reset_out got %h exp 0", {O_red, O_green, O_blue, hs, vs});
    end
    rst = 1'b0;

    // Hsync edge positions counted from the first edge after release.
    rise1 = -1; rise2 = -1; hs_width = 0; hs_prev = 1'b0;
    for (int e = 1; e <= 3400; e++) begin
      @(posedge clk); #1;
      if (hs && !hs_prev) begin
        if (rise1 < 0) rise1 = e;
        else if (rise2 < 0) rise2 = e;
      end
      if (hs && e <= 1688) hs_width++;
      hs_prev = hs;
    end
    n_assert++;
    assert (rise1 == 1329) else begin
      n_fail++; $error("FAIL hs_rise got %0d exp 1329", rise1);
    end
    n_assert++;
    assert (hs_width == 112) else begin
      n_fail++; $error("FAIL hs_width got %0d exp 112", hs_width);
    end
    n_assert++;
    assert (rise2 == 1329 + 1688) else begin
      n_fail++; $error("FAIL hs_period got %0d exp %0d", rise2, 1329 + 1688);
    end

    // Frame 1: view_q still 0.
    @(negedge clk); force dut.u_sync.vcnt_q = 11'd660; vm = 660; vforced = 1;
    check_pix(330, 660, 12'hFA0, "f1_block");
    check_pix(200, 660, 12'h59F, "f1_sky");
    check_pix(320, 660, 12'h000, "f1_border");
    @(negedge clk); force dut.u_sync.vcnt_q = 11'd100; vm = 100;
    check_pix(10, 100, 12'h59F, "f1_sky_top");

    // Vertical blanking and vsync decode.
    @(negedge clk); force dut.u_sync.vcnt_q = 11'd1024; vm = 1024;
    check_pix(10, 1024, 12'h000, "vblank");
    n_assert++;
    assert (vs === 1'b0) else begin n_fail++; $error("FAIL vs_1024 got %b exp 0", vs); end
    @(negedge clk); force dut.u_sync.vcnt_q = 11'd1025; vm = 1025;
    check_pix(0, 1025, 12'h000, "vs_line_1025");
    n_assert++;
    assert (vs === 1'b1) else begin n_fail++; $error("FAIL vs_1025 got %b exp 1", vs); end
    @(negedge clk); force dut.u_sync.vcnt_q = 11'd1027; vm = 1027;
    check_pix(10, 1027, 12'h000, "vs_line_1027");
    n_assert++;
    assert (vs === 1'b1) else begin n_fail++; $error("FAIL vs_1027 got %b exp 1", vs); end
    @(negedge clk); force dut.u_sync.vcnt_q = 11'd1028; vm = 1028;
    check_pix(10, 1028, 12'h000, "vs_line_1028");
    n_assert++;
    assert (vs === 1'b0) else begin n_fail++; $error("FAIL vs_1028 got %b exp 0", vs); end

    // Last line of the frame: camera latches at (1687,1065).
    @(negedge clk); force dut.u_sync.vcnt_q = 11'd1065; vm = 1065;
    check_pix(1687, 1065, 12'h000, "frame_end");

    // Frame 2: view_q = 10.
    @(negedge clk); force dut.u_sync.vcnt_q = 11'd660; vm = 660;
    check_pix(200, 660, 12'hFA0, "f2_block");
    check_pix(330, 660, 12'h59F, "f2_sky");
    check_pix(710, 660, 12'hFA0, "f2_block2");
    check_pix(1250, 660, 12'hFA0, "f2_block3");
    check_pix(1300, 660, 12'h000, "hblank");
    view = 7'd20;
    check_pix(200, 660, 12'hFA0, "midframe_view");
    @(negedge clk); force dut.u_sync.vcnt_q = 11'd900; vm = 900;
    check_pix(10, 900, 12'hC40, "ground");
    check_pix(384, 900, 12'h000, "mortar_x384");
    check_pix(0, 900, 12'h000, "mortar_x0");
    @(negedge clk); force dut.u_sync.vcnt_q = 11'd896; vm = 896;
    check_pix(100, 896, 12'h000, "mortar_y896");
    @(negedge clk); force dut.u_sync.vcnt_q = 11'd928; vm = 928;
    check_pix(500, 928, 12'h000, "mortar_y928");
    check_pix(501, 928, 12'h000, "mortar_y928b");

    // Return to normal counting through a reset.
    @(negedge clk);
    release dut.u_sync.vcnt_q;
    vforced = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_assert++;
    assert ({O_red, O_green, O_blue, hs, vs} === 14'd0)
    else begin
      n_fail++;
      $error("FAIL reset_mid got %h exp 0", {O_red, O_green, O_blue, hs, vs});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
